// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - two-requester AXI4 read arbiter with in-order R routing
// Optional ARB_S0_PRIORITY_EN: s0 always wins contention instead of round-robin.

module axi_rd_arbiter #(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int C_MAX_OUTSTANDING  = 16,
  parameter int C_CNT_WIDTH        = $clog2(C_MAX_OUTSTANDING) + 1
) (
  input  logic                          data_clk,
  input  logic                          data_rst_n,

  input  logic                          s0_arvalid,
  output logic                          s0_arready,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] s0_araddr,
  input  logic [7:0]                    s0_arlen,
  output logic                          s0_rvalid,
  input  logic                          s0_rready,
  output logic [C_M_AXI_DATA_WIDTH-1:0] s0_rdata,
  output logic                          s0_rlast,

  input  logic                          s1_arvalid,
  output logic                          s1_arready,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] s1_araddr,
  input  logic [7:0]                    s1_arlen,
  output logic                          s1_rvalid,
  input  logic                          s1_rready,
  output logic [C_M_AXI_DATA_WIDTH-1:0] s1_rdata,
  output logic                          s1_rlast,

  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic                          m_axi_rlast,

  output logic [C_CNT_WIDTH-1:0]        outstanding,
  output logic                          busy,
  output logic                          rd_err
);

  localparam int PTR_W = $clog2(C_MAX_OUTSTANDING);
  localparam logic [C_CNT_WIDTH-1:0] MAX_CNT = C_CNT_WIDTH'(C_MAX_OUTSTANDING);

  logic                          ar_valid_q;
  logic [C_M_AXI_ADDR_WIDTH-1:0] ar_addr_q;
  logic [7:0]                    ar_len_q;

  // Order FIFO: one bit per burst naming the requester that owns it.
  logic                          order_q [C_MAX_OUTSTANDING];
  logic [PTR_W-1:0]              wr_ptr_q;
  logic [PTR_W-1:0]              rd_ptr_q;
  logic [C_CNT_WIDTH-1:0]        cnt_q;
  logic                          rd_err_q;

  logic credit_ok;
  logic slot_free;
  logic grant_0;
  logic grant_1;
  logic push;
  logic push_id;
  logic pop;
  logic empty;
  logic head;

`ifdef ARB_S0_PRIORITY_EN
  always_comb begin
    grant_0 = s0_arvalid;
    grant_1 = s1_arvalid & ~s0_arvalid;
  end
`else
  logic last_grant_q;

  // On contention the requester that did not win last time goes next.
  always_comb begin
    grant_0 = s0_arvalid & (~s1_arvalid | last_grant_q);
    grant_1 = s1_arvalid & (~s0_arvalid | ~last_grant_q);
  end

  always_ff @(posedge data_clk) begin
    if (!data_rst_n) begin
      last_grant_q <= 1'b1;
    end else if (push) begin
      last_grant_q <= push_id;
    end
  end
`endif

  always_comb begin
    credit_ok  = cnt_q < MAX_CNT;
    slot_free  = ~ar_valid_q | m_axi_arready;
    s0_arready = grant_0 & credit_ok & slot_free & data_rst_n;
    s1_arready = grant_1 & credit_ok & slot_free & data_rst_n;
    push       = (s0_arvalid & s0_arready) | (s1_arvalid & s1_arready);
    push_id    = s1_arready;
  end

  always_comb begin
    empty        = (cnt_q == '0);
    head         = order_q[rd_ptr_q];
    s0_rvalid    = data_rst_n & m_axi_rvalid & ~empty & ~head;
    s1_rvalid    = data_rst_n & m_axi_rvalid & ~empty & head;
    m_axi_rready = data_rst_n & ~empty & (head ? s1_rready : s0_rready);
    pop          = m_axi_rvalid & m_axi_rready & m_axi_rlast;
  end

  assign s0_rdata = m_axi_rdata;
  assign s1_rdata = m_axi_rdata;
  assign s0_rlast = m_axi_rlast;
  assign s1_rlast = m_axi_rlast;

  // A new accept only happens when the slot is free, so it may overwrite.
  always_ff @(posedge data_clk) begin
    if (!data_rst_n) begin
      ar_valid_q <= 1'b0;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
    end else if (push) begin
      ar_valid_q <= 1'b1;
      ar_addr_q  <= push_id ? s1_araddr : s0_araddr;
      ar_len_q   <= push_id ? s1_arlen : s0_arlen;
    end else if (m_axi_arready) begin
      ar_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge data_clk) begin
    if (push) begin
      order_q[wr_ptr_q] <= push_id;
    end
  end

  always_ff @(posedge data_clk) begin
    if (!data_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      rd_err_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (m_axi_rvalid & empty) begin
        rd_err_q <= 1'b1;
      end
    end
  end

  assign m_axi_arvalid = ar_valid_q;
  assign m_axi_araddr  = ar_addr_q;
  assign m_axi_arlen   = ar_len_q;
  assign outstanding   = cnt_q;
  assign busy          = (cnt_q != '0) | ar_valid_q;
  assign rd_err        = rd_err_q;

endmodule
